regfile_scoreboard: RTL

- Parametrised successor to the single-write, two-read register file used in the register stage.
- Provides READ_PORTS combinational read ports with same-cycle write-back bypass and WRITE_PORTS write ports for multi-issue or split ALU/load write-back.
- Adds a per-register pending-write scoreboard with saturating in-flight counters. The register stage uses it to stall on RAW hazards that forwarding cannot cover.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard_pending_counter.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with pending-write scoreboard.
// Width helpers are functions so each module derives widths from its own parameters.
package regfile_pkg;

    localparam int DEF_REG_COUNT   = 32;
    localparam int DEF_MAX_PENDING = 3;

    function automatic int adr_width(input int reg_count);
        return $clog2(reg_count);
    endfunction

    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int DEF_AW = adr_width(DEF_REG_COUNT);
    localparam int DEF_CW = cnt_width(DEF_MAX_PENDING);

    typedef logic [DEF_AW-1:0] regAdr_t;

    localparam regAdr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// Saturating up/down in-flight write counter for one register.
// Flush wins over issue and retire; the count clamps to [0, MAX_PENDING].
module pending_counter
    import regfile_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int RW          = 1,
    localparam int CW         = cnt_width(MAX_PENDING)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          inc,
    input  logic [RW-1:0] dec,
    output logic [CW-1:0] cnt
);

    int            sum;
    logic [CW-1:0] cnt_next;

    // Underflow is legal: a write may retire an op issued before a flush.
    always_comb begin
        sum      = int'(cnt) + (inc ? 1 : 0) - int'(dec);
        cnt_next = cnt;
        if (flush)
            cnt_next = '0;
        else if (sum < 0)
            cnt_next = '0;
        else if (sum > MAX_PENDING)
            cnt_next = CW'(MAX_PENDING);
        else
            cnt_next = CW'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending-write scoreboard used to stall RAW hazards forwarding cannot cover.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_COUNT   = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int MAX_PENDING = 3,
    localparam int AW         = adr_width(REG_COUNT),
    localparam int CW         = cnt_width(MAX_PENDING)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [READ_PORTS-1:0][AW-1:0]       RdAdr_R,
    output logic [READ_PORTS-1:0][XLEN-1:0]     RdData_R,
    output logic [READ_PORTS-1:0]               RdBusy_R,
    input  logic                                Issue_R,
    input  logic [AW-1:0]                       IssueAdr_R,
    output logic                                IssueReady_R,
    input  logic [WRITE_PORTS-1:0]              WriteEn_W,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      WriteAdr_W,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]    WriteData_W,
    input  logic                                Flush
);

    localparam int          RW       = $clog2(WRITE_PORTS + 1);
    localparam logic [AW-1:0] ZERO_ADR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs        [REG_COUNT];
    logic [RW-1:0]   retire_cnt  [REG_COUNT];
    logic [CW-1:0]   cnt         [REG_COUNT];
    logic            issue_accept;
    int              issue_net;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++)
                regs[r] <= '0;
        end else begin
            for (int k = 0; k < WRITE_PORTS; k++)
                if (WriteEn_W[k] && WriteAdr_W[k] != ZERO_ADR)
                    regs[WriteAdr_W[k]] <= WriteData_W[k];
        end
    end

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            retire_cnt[r] = '0;
            for (int k = 0; k < WRITE_PORTS; k++)
                if (r != 0 && WriteEn_W[k] && WriteAdr_W[k] == AW'(r))
                    retire_cnt[r] = retire_cnt[r] + RW'(1);
        end
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_cnt
        pending_counter #(
            .MAX_PENDING (MAX_PENDING),
            .RW          (RW)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .flush (Flush),
            .inc   (issue_accept && IssueAdr_R == AW'(r)),
            .dec   (retire_cnt[r]),
            .cnt   (cnt[r])
        );
    end

    // Ready looks only at the address, never at Issue_R, so there is no loop.
    always_comb begin
        issue_net = 0;
        if (int'(cnt[IssueAdr_R]) > int'(retire_cnt[IssueAdr_R]))
            issue_net = int'(cnt[IssueAdr_R]) - int'(retire_cnt[IssueAdr_R]);
        IssueReady_R = (issue_net < MAX_PENDING);
    end

    assign issue_accept = Issue_R && IssueReady_R && (IssueAdr_R != ZERO_ADR);

    // A write retiring this cycle is served by the bypass, so it is not busy.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            RdData_R[i] = regs[RdAdr_R[i]];
            for (int k = 0; k < WRITE_PORTS; k++)
                if (WriteEn_W[k] && WriteAdr_W[k] == RdAdr_R[i])
                    RdData_R[i] = WriteData_W[k];
            if (reset || RdAdr_R[i] == ZERO_ADR)
                RdData_R[i] = '0;
            RdBusy_R[i] = (int'(cnt[RdAdr_R[i]]) > int'(retire_cnt[RdAdr_R[i]]));
        end
    end

endmodule
